path_count_scheduler: RTL and testbench

- Controller for the forward-pass stage of the device-graph solver.
- After edge loading completes, it drains the topologically sorted node stream and walks each node's adjacency range.
- For each edge it performs a serialized read-modify-write on an external path-count memory, accumulating the number of paths from SRC_NODE.
- It then reads the count of DST_NODE and presents it as the result for the TAP encoder.

---
 rtl/path_count_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_path_count_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_count_scheduler.sv
// Forward-pass path-count scheduler for the device-graph solver.
// Serialized read-modify-write of path counts along topological order.
module path_count_scheduler #(
    parameter int unsigned NODE_WIDTH = 15,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned EDGE_ADDR_WIDTH = 11,
    parameter logic [NODE_WIDTH-1:0] SRC_NODE = 15'h61D4,
    parameter logic [NODE_WIDTH-1:0] DST_NODE = 15'h3A93
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       order_valid,
    output logic                       order_ready,
    input  logic [NODE_WIDTH-1:0]      order_node,
    input  logic                       order_last,
    output logic                       adj_req,
    output logic [NODE_WIDTH-1:0]      adj_node,
    input  logic [EDGE_ADDR_WIDTH-1:0] adj_base,
    input  logic [EDGE_ADDR_WIDTH-1:0] adj_count,
    output logic                       edge_rd_en,
    output logic [EDGE_ADDR_WIDTH-1:0] edge_rd_addr,
    input  logic [NODE_WIDTH-1:0]      edge_rd_dst,
    output logic                       cnt_rd_en,
    output logic [NODE_WIDTH-1:0]      cnt_rd_addr,
    input  logic [COUNT_WIDTH-1:0]     cnt_rd_data,
    output logic                       cnt_wr_en,
    output logic [NODE_WIDTH-1:0]      cnt_wr_addr,
    output logic [COUNT_WIDTH-1:0]     cnt_wr_data,
    output logic                       busy,
    output logic                       result_valid,
    output logic [COUNT_WIDTH-1:0]     result_data,
    output logic                       overflow
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_SEED,
        S_FETCH,
        S_SELF_WAIT,
        S_EDGE_RD,
        S_EDGE_WAIT,
        S_CNT_WAIT,
        S_CNT_WR,
        S_FINAL,
        S_FINAL_WAIT
    } state_t;

    state_t                     state_q, state_d;
    logic [NODE_WIDTH-1:0]      clr_addr_q, clr_addr_d;
    logic                       last_q, last_d;
    logic [COUNT_WIDTH-1:0]     cur_count_q, cur_count_d;
    logic [EDGE_ADDR_WIDTH-1:0] base_q, base_d;
    logic [EDGE_ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [NODE_WIDTH-1:0]      dst_q, dst_d;
    logic                       result_valid_q, result_valid_d;
    logic [COUNT_WIDTH-1:0]     result_data_q, result_data_d;
    logic                       overflow_q, overflow_d;
    logic [COUNT_WIDTH:0]       sum;

    assign busy         = (state_q != S_IDLE);
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign overflow     = overflow_q;

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            clr_addr_q     <= '0;
            last_q         <= 1'b0;
            cur_count_q    <= '0;
            base_q         <= '0;
            remaining_q    <= '0;
            dst_q          <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_addr_q     <= clr_addr_d;
            last_q         <= last_d;
            cur_count_q    <= cur_count_d;
            base_q         <= base_d;
            remaining_q    <= remaining_d;
            dst_q          <= dst_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            overflow_q     <= overflow_d;
        end
    end

    // Next-state, memory strobes and saturating accumulate.
    always_comb begin
        state_d        = state_q;
        clr_addr_d     = clr_addr_q;
        last_d         = last_q;
        cur_count_d    = cur_count_q;
        base_d         = base_q;
        remaining_d    = remaining_q;
        dst_d          = dst_q;
        result_valid_d = result_valid_q;
        result_data_d  = result_data_q;
        overflow_d     = overflow_q;
        order_ready    = 1'b0;
        adj_req        = 1'b0;
        adj_node       = '0;
        edge_rd_en     = 1'b0;
        edge_rd_addr   = '0;
        cnt_rd_en      = 1'b0;
        cnt_rd_addr    = '0;
        cnt_wr_en      = 1'b0;
        cnt_wr_addr    = '0;
        cnt_wr_data    = '0;
        sum = {1'b0, cnt_rd_data} + {1'b0, cur_count_q};
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_CLEAR;
                    clr_addr_d     = '0;
                    result_valid_d = 1'b0;
                    overflow_d     = 1'b0;
                end
            end
            S_CLEAR: begin
                cnt_wr_en   = 1'b1;
                cnt_wr_addr = clr_addr_q;
                clr_addr_d  = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                cnt_wr_en   = 1'b1;
                cnt_wr_addr = SRC_NODE;
                cnt_wr_data = COUNT_WIDTH'(1);
                state_d     = S_FETCH;
            end
            S_FETCH: begin
                order_ready = 1'b1;
                if (order_valid) begin
                    last_d      = order_last;
                    cnt_rd_en   = 1'b1;
                    cnt_rd_addr = order_node;
                    adj_req     = 1'b1;
                    adj_node    = order_node;
                    state_d     = S_SELF_WAIT;
                end
            end
            S_SELF_WAIT: begin
                cur_count_d = cnt_rd_data;
                base_d      = adj_base;
                remaining_d = adj_count;
                if (cnt_rd_data == '0 || adj_count == '0) begin
                    state_d = last_q ? S_FINAL : S_FETCH;
                end else begin
                    state_d = S_EDGE_RD;
                end
            end
            S_EDGE_RD: begin
                edge_rd_en   = 1'b1;
                edge_rd_addr = base_q;
                state_d      = S_EDGE_WAIT;
            end
            S_EDGE_WAIT: begin
                dst_d       = edge_rd_dst;
                cnt_rd_en   = 1'b1;
                cnt_rd_addr = edge_rd_dst;
                state_d     = S_CNT_WAIT;
            end
            S_CNT_WAIT: begin
                cnt_wr_en   = 1'b1;
                cnt_wr_addr = dst_q;
                if (sum[COUNT_WIDTH]) begin
                    cnt_wr_data = '1;
                    overflow_d  = 1'b1;
                end else begin
                    cnt_wr_data = sum[COUNT_WIDTH-1:0];
                end
                state_d = S_CNT_WR;
            end
            S_CNT_WR: begin
                base_d      = base_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == EDGE_ADDR_WIDTH'(1)) begin
                    state_d = last_q ? S_FINAL : S_FETCH;
                end else begin
                    state_d = S_EDGE_RD;
                end
            end
            S_FINAL: begin
                cnt_rd_en   = 1'b1;
                cnt_rd_addr = DST_NODE;
                state_d     = S_FINAL_WAIT;
            end
            S_FINAL_WAIT: begin
                result_data_d  = cnt_rd_data;
                result_valid_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_path_count_scheduler.sv
// Scoreboard bench for path_count_scheduler with behavioural memories.
// Runs at reduced node width so each CLEAR phase stays short.
module tb_path_count_scheduler;

    localparam int NW = 10;
    localparam int CW = 16;
    localparam int EW = 11;
    localparam logic [NW-1:0] YOU = 10'h1D4;
    localparam logic [NW-1:0] OUT = 10'h293;
    localparam logic [NW-1:0] AAA = 10'h000;
    localparam logic [NW-1:0] BBB = 10'h021;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          order_valid;
    logic          order_ready;
    logic [NW-1:0] order_node;
    logic          order_last;
    logic          adj_req;
    logic [NW-1:0] adj_node;
    logic [EW-1:0] adj_base;
    logic [EW-1:0] adj_count;
    logic          edge_rd_en;
    logic [EW-1:0] edge_rd_addr;
    logic [NW-1:0] edge_rd_dst;
    logic          cnt_rd_en;
    logic [NW-1:0] cnt_rd_addr;
    logic [CW-1:0] cnt_rd_data;
    logic          cnt_wr_en;
    logic [NW-1:0] cnt_wr_addr;
    logic [CW-1:0] cnt_wr_data;
    logic          busy;
    logic          result_valid;
    logic [CW-1:0] result_data;
    logic          overflow;

    path_count_scheduler #(
        .NODE_WIDTH(NW),
        .COUNT_WIDTH(CW),
        .EDGE_ADDR_WIDTH(EW),
        .SRC_NODE(YOU),
        .DST_NODE(OUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .order_valid(order_valid),
        .order_ready(order_ready),
        .order_node(order_node),
        .order_last(order_last),
        .adj_req(adj_req),
        .adj_node(adj_node),
        .adj_base(adj_base),
        .adj_count(adj_count),
        .edge_rd_en(edge_rd_en),
        .edge_rd_addr(edge_rd_addr),
        .edge_rd_dst(edge_rd_dst),
        .cnt_rd_en(cnt_rd_en),
        .cnt_rd_addr(cnt_rd_addr),
        .cnt_rd_data(cnt_rd_data),
        .cnt_wr_en(cnt_wr_en),
        .cnt_wr_addr(cnt_wr_addr),
        .cnt_wr_data(cnt_wr_data),
        .busy(busy),
        .result_valid(result_valid),
        .result_data(result_data),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] res;
        logic          ov;
        int            wr;
        int            dwr;
    } exp_t;

    exp_t          exp_q[$];
    logic [NW-1:0] ord[$];
    logic [CW-1:0] cnt_mem [0:1023];
    logic [EW-1:0] base_tbl [0:1023];
    logic [EW-1:0] deg_tbl [0:1023];
    logic [NW-1:0] edge_tbl [0:2047];

    int   tests = 0;
    int   fails = 0;
    int   wr_cnt = 0;
    int   dwr_cnt = 0;
    bit   seen_seed = 0;
    bit   abort = 0;
    logic rv_prev = 1'b0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Memory models: count RAM, adjacency table, edge RAM.
    always @(posedge clk) begin
        if (cnt_wr_en) cnt_mem[cnt_wr_addr] <= cnt_wr_data;
        if (cnt_rd_en) cnt_rd_data <= cnt_mem[cnt_rd_addr];
        if (adj_req) begin
            adj_base  <= base_tbl[adj_node];
            adj_count <= deg_tbl[adj_node];
        end
        if (edge_rd_en) edge_rd_dst <= edge_tbl[edge_rd_addr];
    end

    // Write tracking and read/write exclusivity.
    always @(negedge clk) begin
        if (start && !busy) begin
            seen_seed = 0;
            wr_cnt    = 0;
            dwr_cnt   = 0;
        end
        if (cnt_rd_en && cnt_wr_en) begin
            fails++;
            $display("FAIL rd_wr_overlap: got 1 expected 0");
        end
        if (cnt_wr_en) begin
            if (seen_seed) begin
                wr_cnt++;
                if (cnt_wr_addr == OUT) dwr_cnt++;
            end else if (cnt_wr_addr == YOU && cnt_wr_data == 1) begin
                seen_seed = 1;
            end
        end
    end

    // Scoreboard monitor: compare on each rising result_valid.
    always @(negedge clk) begin
        exp_t e;
        rv_prev <= result_valid;
        if (result_valid && !rv_prev) begin
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got %0h expected none",
                         result_data);
            end else begin
                e = exp_q.pop_front();
                check("result_data", 32'(result_data), 32'(e.res));
                check("overflow", 32'(overflow), 32'(e.ov));
                check("writes_after_seed", wr_cnt, e.wr);
                check("dst_writes", dwr_cnt, e.dwr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_graph();
        for (int i = 0; i < 1024; i++) begin
            base_tbl[i] = '0;
            deg_tbl[i]  = '0;
        end
        ord.delete();
    endtask

    task automatic set_adj(input logic [NW-1:0] n, input int b, input int d);
        base_tbl[n] = EW'(b);
        deg_tbl[n]  = EW'(d);
    endtask

    task automatic hold_stream();
        bit r;
        bit rdy_ok;
        bit busy_ok;
        int g;
        order_valid = 1'b0;
        g = 0;
        do begin
            @(negedge clk);
            r = order_ready;
            step();
            g++;
        end while (!r && g < 4000);
        rdy_ok  = 1;
        busy_ok = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!order_ready) rdy_ok = 0;
            if (!busy || result_valid) busy_ok = 0;
            step();
            start = (k == 20);
        end
        start = 1'b0;
        check("hold_ready", 32'(rdy_ok), 1);
        check("hold_busy", 32'(busy_ok), 1);
    endtask

    task automatic feed(input int hold_idx);
        bit acc;
        int g;
        for (int i = 0; i < ord.size(); i++) begin
            if (abort) break;
            if (i == hold_idx) hold_stream();
            order_valid = 1'b1;
            order_node  = ord[i];
            order_last  = (i == ord.size() - 1);
            g = 0;
            do begin
                @(negedge clk);
                acc = order_ready;
                step();
                g++;
            end while (!acc && g < 4000 && !abort);
            if (!acc && !abort) begin
                fails++;
                $display("FAIL stream_timeout: got idx %0d expected accept", i);
            end
        end
        order_valid = 1'b0;
        order_last  = 1'b0;
    endtask

    task automatic wait_result();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!result_valid && g < 20000);
        if (!result_valid) begin
            fails++;
            $display("FAIL result_timeout: got 0 expected 1");
        end
        step();
    endtask

    task automatic run(input exp_t e, input int hold_idx, input bit chk_busy);
        exp_q.push_back(e);
        start = 1'b1;
        step();
        start = 1'b0;
        if (chk_busy) check("busy_after_start", 32'(busy), 1);
        feed(hold_idx);
        wait_result();
    endtask

    task automatic build_chain();
        clr_graph();
        set_adj(YOU, 0, 1);
        edge_tbl[0] = AAA;
        set_adj(AAA, 1, 1);
        edge_tbl[1] = OUT;
        ord.push_back(YOU);
        ord.push_back(AAA);
        ord.push_back(OUT);
    endtask

    task automatic build_diamond();
        clr_graph();
        set_adj(YOU, 2047, 2);
        edge_tbl[2047] = AAA;
        edge_tbl[0]    = BBB;
        set_adj(AAA, 1, 1);
        edge_tbl[1] = OUT;
        set_adj(BBB, 2, 1);
        edge_tbl[2] = OUT;
        ord.push_back(YOU);
        ord.push_back(AAA);
        ord.push_back(BBB);
        ord.push_back(OUT);
    endtask

    task automatic build_ladder();
        logic [NW-1:0] lv [0:16];
        clr_graph();
        lv[0]  = YOU;
        lv[16] = OUT;
        for (int i = 1; i < 16; i++) lv[i] = NW'(10'h100 + i);
        for (int i = 0; i < 16; i++) begin
            set_adj(lv[i], 2 * i, 2);
            edge_tbl[2 * i]     = lv[i + 1];
            edge_tbl[2 * i + 1] = lv[i + 1];
        end
        for (int i = 0; i < 17; i++) ord.push_back(lv[i]);
    endtask

    task automatic abort_run();
        int g;
        abort = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        fork
            feed(-1);
            begin
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!(cnt_wr_en && cnt_wr_addr == AAA &&
                             cnt_wr_data == 1) && g < 20000);
                if (g >= 20000) begin
                    fails++;
                    $display("FAIL cnt_wait_timeout: got 0 expected 1");
                end
                rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 0);
                check("rst_cnt_wr_en", 32'(cnt_wr_en), 0);
                check("rst_cnt_wr_data", 32'(cnt_wr_data), 0);
                check("rst_rd_strobes",
                      32'({cnt_rd_en, edge_rd_en, adj_req, order_ready}), 0);
                check("rst_result_data", 32'(result_data), 0);
                check("rst_flags", 32'({result_valid, overflow}), 0);
                abort = 1;
            end
        join
        step();
        step();
        rst_n = 1'b1;
        abort = 0;
        step();
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        order_valid = 1'b0;
        order_node  = '0;
        order_last  = 1'b0;
        repeat (3) step();
        check("reset_flags", 32'({busy, result_valid, overflow}), 0);
        check("reset_result", 32'(result_data), 0);
        check("reset_strobes",
              32'({order_ready, adj_req, edge_rd_en, cnt_rd_en, cnt_wr_en}), 0);
        check("reset_addrs", 32'({cnt_wr_addr, cnt_rd_addr, edge_rd_addr}), 0);
        rst_n = 1'b1;
        step();

        build_chain();
        run('{res: 16'd1, ov: 1'b0, wr: 2, dwr: 1}, -1, 1'b1);

        build_diamond();
        run('{res: 16'd2, ov: 1'b0, wr: 4, dwr: 2}, -1, 1'b0);

        clr_graph();
        set_adj(YOU, 0, 1);
        edge_tbl[0] = AAA;
        ord.push_back(YOU);
        ord.push_back(AAA);
        ord.push_back(OUT);
        run('{res: 16'd0, ov: 1'b0, wr: 1, dwr: 0}, -1, 1'b0);

        build_ladder();
        run('{res: 16'hFFFF, ov: 1'b1, wr: 32, dwr: 2}, -1, 1'b0);

        build_diamond();
        run('{res: 16'd2, ov: 1'b0, wr: 4, dwr: 2}, 1, 1'b0);

        build_chain();
        abort_run();
        check("post_abort_idle", 32'({busy, result_valid}), 0);

        build_chain();
        run('{res: 16'd1, ov: 1'b0, wr: 2, dwr: 1}, -1, 1'b0);

        repeat (3) step();
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_results: got %0d expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
